// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data memory arbiter with locked port-1 bursts and a starvation bound
//
// Purpose: shares one single-ported data memory between the MEM stage (port 0)
// and the loader/debug port (port 1). One grant per cycle at most, combinational;
// ack/err/rdata are returned one cycle after the grant.
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset
//   req0/we0/addr0/wdata0         port 0 request (held until gnt0)
//   gnt0/stall0/ack0/rdata0/err0  port 0 grant, pipeline stall, response
//   req1/we1/addr1/wdata1/lock1   port 1 request; lock1 asks for burst ownership
//   gnt1/ack1/rdata1/err1         port 1 grant and response
//   mem_addr/mem_wdata            memory address/write data (granted port)
//   mem_read/mem_write            memory strobes (suppressed out of range)
//   mem_rdata                     memory read data, combinational from mem_addr
module dmem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int ADDR_LIMIT   = 4096,
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_BURST    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          stall0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  output logic          err0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          err1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SCW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int BCW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);
  // Count value before the final beat; that beat closes the burst.
  localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
  // One extra bit so a limit equal to 2**AW still compares correctly.
  localparam logic [AW:0]    LIMIT_W    = (AW + 1)'(ADDR_LIMIT);

  typedef enum logic {IDLE, BURST1} state_t;

  state_t         state, state_d;
  logic [SCW-1:0] starve_cnt, starve_d;
  logic [BCW-1:0] burst_cnt, burst_d;
  logic           yield_q, yield_d;
  logic           sel_we;
  logic           legal;

  // Grant selection. Grants are forced low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      if (state == BURST1) begin
        gnt1 = req1;
      end else if (yield_q && req0) begin
        gnt0 = 1'b1;
      end else if (req0 && req1) begin
        if (starve_cnt == STARVE_MAX) gnt1 = 1'b1;
        else                          gnt0 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign stall0 = req0 & ~gnt0;

  // Without a port-1 grant the memory bus shows port 0's request.
  assign mem_addr  = gnt1 ? addr1  : addr0;
  assign mem_wdata = gnt1 ? wdata1 : wdata0;
  assign sel_we    = gnt1 ? we1    : we0;
  assign legal     = {1'b0, mem_addr} < LIMIT_W;
  assign mem_read  = (gnt0 | gnt1) & ~sel_we & legal;
  assign mem_write = (gnt0 | gnt1) &  sel_we & legal;

  // Burst FSM, starvation counter and post-burst yield flag.
  always_comb begin
    state_d = state;
    burst_d = burst_cnt;
    yield_d = 1'b0;
    case (state)
      IDLE: begin
        if (gnt1 && lock1) begin
          if (MAX_BURST <= 1) begin
            yield_d = 1'b1;
          end else begin
            state_d = BURST1;
            burst_d = BCW'(1);
          end
        end
      end
      BURST1: begin
        if (!req1 || !lock1) begin
          state_d = IDLE;
        end else if (burst_cnt == BURST_LAST) begin
          state_d = IDLE;
          yield_d = 1'b1;
          burst_d = burst_cnt + BCW'(1);
        end else begin
          burst_d = burst_cnt + BCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    starve_d = starve_cnt;
    if (!req1 || gnt1)                 starve_d = '0;
    else if (starve_cnt != STARVE_MAX) starve_d = starve_cnt + SCW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      yield_q    <= 1'b0;
      ack0       <= 1'b0;
      err0       <= 1'b0;
      rdata0     <= '0;
      ack1       <= 1'b0;
      err1       <= 1'b0;
      rdata1     <= '0;
    end else begin
      state      <= state_d;
      starve_cnt <= starve_d;
      burst_cnt  <= burst_d;
      yield_q    <= yield_d;
      ack0       <= gnt0;
      err0       <= gnt0 & ~legal;
      ack1       <= gnt1;
      err1       <= gnt1 & ~legal;
      if (gnt0 && mem_read) rdata0 <= mem_rdata;
      if (gnt1 && mem_read) rdata1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard testbench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1, lock1;
  logic [15:0] addr0, wdata0, addr1, wdata1;
  logic        gnt0, stall0, ack0, err0, gnt1, ack1, err1;
  logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [15:0] mem    [0:65535];
  logic [15:0] shadow [0:65535];

  typedef struct packed {
    logic        we;
    logic        err;
    logic [15:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .stall0(stall0), .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected responses are queued when a grant is seen and
  // checked when the matching ack arrives. Reset drops anything in flight.
  always @(negedge clk) begin
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (ack0) begin
        check("ack0_pending", 32'(q0.size() > 0), 32'd1);
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check("err0", 32'(err0), 32'(e.err));
          if (!e.we && !e.err) check("rdata0", 32'(rdata0), 32'(e.data));
        end
      end
      if (ack1) begin
        check("ack1_pending", 32'(q1.size() > 0), 32'd1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("err1", 32'(err1), 32'(e.err));
          if (!e.we && !e.err) check("rdata1", 32'(rdata1), 32'(e.data));
        end
      end
      if (gnt0) begin
        q0.push_back('{we: we0, err: (addr0 >= 16'd4096), data: shadow[addr0]});
        if (we0 && addr0 < 16'd4096) shadow[addr0] = wdata0;
      end
      if (gnt1) begin
        q1.push_back('{we: we1, err: (addr1 >= 16'd4096), data: shadow[addr1]});
        if (we1 && addr1 < 16'd4096) shadow[addr1] = wdata1;
      end
    end
  end

  task automatic access(input int port, input logic w, input logic [15:0] a, input logic [15:0] d);
    logic got;
    got = 1'b0;
    if (port == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else           begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      got = (port == 0) ? gnt0 : gnt1;
      @(posedge clk); #1;
    end
    check($sformatf("grant_p%0d_%h", port, a), 32'(got), 32'd1);
    if (port == 0) req0 = 1'b0;
    else           req1 = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic g1;
    logic e1;
    int   beat;
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = 16'(i) ^ 16'h5A5A;
      shadow[i] = 16'(i) ^ 16'h5A5A;
    end
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;

    // T1: reset holds everything quiet even with a pending write.
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'hBEEF;
    @(negedge clk);
    check("t1_rst_gnt0", 32'(gnt0), 32'd0);
    check("t1_rst_mem_write", 32'(mem_write), 32'd0);
    check("t1_rst_ack0", 32'(ack0), 32'd0);
    check("t1_rst_rdata0", 32'(rdata0), 32'd0);
    check("t1_rst_rdata1", 32'(rdata1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t1_gnt0_after_rst", 32'(gnt0), 32'd1);
    check("t1_mem_write", 32'(mem_write), 32'd1);
    check("t1_ack0_same_cycle", 32'(ack0), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("t1_ack0_next", 32'(ack0), 32'd1);
    @(posedge clk); #1;

    // T2: read back the written word.
    access(0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    check("t2_ack0", 32'(ack0), 32'd1);
    check("t2_rdata0", 32'(rdata0), 32'h0000BEEF);
    check("t2_err0", 32'(err0), 32'd0);
    @(posedge clk); #1;

    // T3: continuous conflict, port 1 wins on the fifth cycle only.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0030;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      e1 = (c == 5);
      check($sformatf("t3_gnt1_c%0d", c), 32'(gnt1), 32'(e1));
      check($sformatf("t3_gnt0_c%0d", c), 32'(gnt0), 32'(!e1));
      check($sformatf("t3_stall0_c%0d", c), 32'(stall0), 32'(e1));
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;

    // T4: locked write burst; four starved cycles, eight beats, then port 0.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0040;
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1;
    beat = 0; addr1 = 16'h0100; wdata1 = 16'hA000;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      g1 = gnt1;
      e1 = (c >= 5 && c <= 12);
      check($sformatf("t4_gnt1_c%0d", c), 32'(gnt1), 32'(e1));
      check($sformatf("t4_gnt0_c%0d", c), 32'(gnt0), 32'(!e1));
      if (e1) check($sformatf("t4_stall0_c%0d", c), 32'(stall0), 32'd1);
      @(posedge clk); #1;
      if (g1) begin
        beat++;
        addr1  = 16'h0100 + 16'(beat);
        wdata1 = 16'hA000 + 16'(beat);
      end
    end
    req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
    @(posedge clk); #1;
    access(0, 1'b0, 16'h0107, 16'h0000);

    // T5: out-of-range write is suppressed and flagged; boundary word is legal.
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'd4096; wdata1 = 16'hDEAD;
    @(negedge clk);
    check("t5_gnt1", 32'(gnt1), 32'd1);
    check("t5_mem_write", 32'(mem_write), 32'd0);
    check("t5_mem_read", 32'(mem_read), 32'd0);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    check("t5_ack1", 32'(ack1), 32'd1);
    check("t5_err1", 32'(err1), 32'd1);
    check("t5_mem_unchanged", 32'(mem[4096]), 32'(16'h1000 ^ 16'h5A5A));
    @(posedge clk); #1;
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'd4095; wdata1 = 16'hBEAD;
    @(negedge clk);
    check("t5_edge_mem_write", 32'(mem_write), 32'd1);
    @(posedge clk); #1;
    req1 = 1'b0;
    @(negedge clk);
    check("t5_edge_err1", 32'(err1), 32'd0);
    check("t5_edge_mem", 32'(mem[4095]), 32'h0000BEAD);
    @(posedge clk); #1;
    access(0, 1'b0, 16'd4096, 16'h0000);
    @(negedge clk);
    check("t5_rd_err0", 32'(err0), 32'd1);
    @(posedge clk); #1;

    // T6: reset on the third burst beat aborts the burst and drops the ack.
    req1 = 1'b1; lock1 = 1'b1; we1 = 1'b0; addr1 = 16'h0101;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("t6_gnt1_c%0d", c), 32'(gnt1), 32'd1);
      if (c < 3) begin @(posedge clk); #1; end
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    req1 = 1'b0; lock1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0103;
    @(negedge clk);
    check("t6_rst_ack1", 32'(ack1), 32'd0);
    check("t6_rst_gnt0", 32'(gnt0), 32'd0);
    check("t6_rst_rdata1", 32'(rdata1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_gnt0_after_rst", 32'(gnt0), 32'd1);
    check("t6_ack1_dropped", 32'(ack1), 32'd0);
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    check("t6_ack0", 32'(ack0), 32'd1);
    check("t6_rdata0", 32'(rdata0), 32'h0000A003);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
